fp32_adder_arbiter: RTL and testbench

Shares one combinational fp32_adder between N requesters. Each request carries operands A and B.
- A round-robin arbiter picks at most one request per cycle.
- The selected sum is captured in a single registered result slot.
- The result is returned to the owning requester over a valid/ready handshake.
Sits between the sparse PE reduction lanes and the single FP32 adder instance in each accelerator tile.

---
 rtl/fp32_arb_pkg.sv | 22 ++
 rtl/fp32_adder.sv | 88 ++++++++
 rtl/rr_arbiter.sv | 38 +++
 rtl/fp32_adder_arbiter.sv | 147 ++++++++++++++
 tb/tb_fp32_adder_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp32_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | fp32_arb_pkg : shared types, FP32 constants and pointer helper             |
// | Revision 1.0 : initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package fp32_arb_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;
  localparam fp32_t FP32_POS_INF  = 32'h7F80_0000;
  localparam fp32_t FP32_ARB_NAN  = 32'h7FFF_FFFF;

  // Round-robin successor of a granted index, wrapping at n.
  function automatic int next_ptr(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp32_adder.sv
// +----------------------------------------------------------------------------+
// | fp32_adder : combinational FP32 add, round-to-nearest-even, flush-to-zero  |
// | Revision 1.0 : initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp32_adder
  import fp32_arb_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t y
);

  logic              sa, sb, sx, sy;
  logic [7:0]        ea, eb, ex, ey, d;
  logic [22:0]       fa, fb, fx, fy, frac;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge;
  logic [26:0]       mx, my, my_sh, nm;
  logic              sticky, rnd;
  logic [27:0]       sum;
  logic [4:0]        msb, lz;
  logic signed [9:0] e_n, e_r;
  logic [24:0]       mant;

  always_comb begin
    y      = FP32_POS_ZERO;
    sticky = 1'b0;
    msb    = 5'd0;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);

    // x is the larger magnitude so the mantissa subtraction never goes negative
    a_ge = {ea, fa} >= {eb, fb};
    sx = a_ge ? sa : sb;  ex = a_ge ? ea : eb;  fx = a_ge ? fa : fb;
    sy = a_ge ? sb : sa;  ey = a_ge ? eb : ea;  fy = a_ge ? fb : fa;
    d  = ex - ey;

    mx = {1'b1, fx, 3'b000};
    my = {1'b1, fy, 3'b000};
    for (int i = 0; i < 27; i++) begin
      if (8'(i) < d) sticky = sticky | my[i];
    end
    my_sh    = (d >= 8'd27) ? 27'd0 : (my >> d);
    my_sh[0] = my_sh[0] | sticky;

    sum = (sx ^ sy) ? ({1'b0, mx} - {1'b0, my_sh}) : ({1'b0, mx} + {1'b0, my_sh});
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) msb = 5'(i);
    end
    lz = 5'd26 - msb;

    if (sum[27]) begin
      nm  = {sum[27:2], sum[1] | sum[0]};
      e_n = {2'b00, ex} + 10'sd1;
    end else begin
      nm  = sum[26:0] << lz;
      e_n = {2'b00, ex} - {5'b00000, lz};
    end

    rnd  = nm[2] & (nm[3] | nm[1] | nm[0]);
    mant = {1'b0, nm[26:3]} + 25'(rnd);
    e_r  = mant[24] ? e_n + 10'sd1 : e_n;
    frac = mant[24] ? mant[23:1] : mant[22:0];

    if (a_nan)                          y = a;
    else if (b_nan)                     y = b;
    else if (a_inf && b_inf && sa != sb) y = FP32_ARB_NAN;
    else if (a_inf)                     y = a;
    else if (b_inf)                     y = b;
    else if (a_zero && b_zero)          y = {sa & sb, 31'd0};
    else if (a_zero)                    y = b;
    else if (b_zero)                    y = a;
    else if (sum == 28'd0)              y = FP32_POS_ZERO;
    else if (e_r <= 0)                  y = {sx, 31'd0};
    else if (e_r >= 255)                y = {sx, FP32_POS_INF[30:0]};
    else                                y = {sx, e_r[7:0], frac};
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter : one-hot round-robin grant, priority starting at ptr           |
// | Revision 1.0 : initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic             found;
  int               pos;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = PTR_W'(pos);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp32_adder_arbiter.sv
// +----------------------------------------------------------------------------+
// | fp32_adder_arbiter : N requesters share one fp32_adder via a result slot   |
// | Optional macro FP32_ADDER_ARB_PERF_EN adds grant/stall counters            |
// | Revision 1.0 : initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp32_adder_arbiter
  import fp32_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*32-1:0]   req_a,
  input  logic [N_REQ*32-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [31:0]           resp_data,
  input  logic [N_REQ-1:0]      resp_ready
`ifdef FP32_ADDER_ARB_PERF_EN
  ,
  output logic [N_REQ*32-1:0]   perf_grant_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  logic [N_REQ-1:0] grant;
  logic             slot_free;
  logic             fire;
  fp32_t            op_a, op_b, sum;
  logic [PTR_W-1:0] sel_idx;

  logic             slot_valid_q, slot_valid_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  fp32_t            slot_data_q, slot_data_d;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Accepting the held result frees the slot in the same cycle, so a new
  // request can be taken with no bubble.
  always_comb begin
    slot_free = !slot_valid_q || resp_ready[owner_q];
    req_ready = (rst_n && slot_free) ? grant : '0;
    fire      = |req_ready;
  end

  always_comb begin
    op_a    = '0;
    op_b    = '0;
    sel_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        op_a    = op_a | req_a[32*i +: 32];
        op_b    = op_b | req_b[32*i +: 32];
        sel_idx = sel_idx | PTR_W'(i);
      end
    end
  end

  fp32_adder u_fp32_adder (
    .a (op_a),
    .b (op_b),
    .y (sum)
  );

  always_comb begin
    slot_valid_d = slot_valid_q;
    owner_d      = owner_q;
    slot_data_d  = slot_data_q;
    ptr_d        = ptr_q;
    if (fire) begin
      slot_valid_d = 1'b1;
      owner_d      = sel_idx;
      slot_data_d  = sum;
      ptr_d        = PTR_W'(next_ptr(int'(sel_idx), N_REQ));
    end else if (slot_valid_q && resp_ready[owner_q]) begin
      slot_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= 1'b0;
      owner_q      <= '0;
      slot_data_q  <= FP32_POS_ZERO;
      ptr_q        <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      owner_q      <= owner_d;
      slot_data_q  <= slot_data_d;
      ptr_q        <= ptr_d;
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      resp_valid[i] = slot_valid_q && (owner_q == PTR_W'(i));
    end
  end

  assign resp_data = slot_data_q;

`ifdef FP32_ADDER_ARB_PERF_EN
  logic [31:0] grant_cnt_q [N_REQ];
  logic [31:0] grant_cnt_d [N_REQ];
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|req_valid) && !(|req_ready) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    for (int i = 0; i < N_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (req_valid[i] && req_ready[i] && (grant_cnt_q[i] != 32'hFFFF_FFFF))
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf_out
    assign perf_grant_cnt[32*gi +: 32] = grant_cnt_q[gi];
  end
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp32_adder_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_fp32_adder_arbiter : directed + random bench with a real-valued model   |
// | Revision 1.0 : initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fp32_adder_arbiter;
  import fp32_arb_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0]     resp_data;
`ifdef FP32_ADDER_ARB_PERF_EN
  logic [N*32-1:0] perf_grant_cnt;
  logic [31:0]     perf_stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  fp32_adder_arbiter #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready)
`ifdef FP32_ADDER_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic via double precision --------------
  function automatic real to_real(input fp32_t v);
    real r;
    int  e;
    r = real'(int'({1'b1, v[22:0]}));
    e = int'(v[30:23]) - 150;
    if (e > 0) repeat (e) r = r * 2.0;
    else       repeat (-e) r = r / 2.0;
    return v[31] ? -r : r;
  endfunction

  function automatic fp32_t from_real(input real r);
    logic [63:0] bits;
    logic [22:0] keep;
    logic [28:0] rem;
    logic [23:0] rk;
    logic        up;
    int          e;
    if (r == 0.0) return 32'h0;
    bits = $realtobits(r);
    e    = int'(bits[62:52]) - 1023 + 127;
    keep = bits[51:29];
    rem  = bits[28:0];
    up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
    rk   = {1'b0, keep} + 24'(up);
    if (rk[23]) e++;
    if (e >= 255) return {bits[63], 8'hFF, 23'h0};
    if (e <= 0)   return {bits[63], 31'h0};
    return {bits[63], e[7:0], rk[22:0]};
  endfunction

  function automatic fp32_t ref_add(input fp32_t a, input fp32_t b);
    logic an, bn, ai, bi;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (an) return a;
    if (bn) return b;
    if (ai && bi && (a[31] != b[31])) return FP32_ARB_NAN;
    if (ai) return a;
    if (bi) return b;
    if (a[30:23] == 0 && b[30:23] == 0) return {a[31] & b[31], 31'h0};
    if (a[30:23] == 0) return b;
    if (b[30:23] == 0) return a;
    return from_real(to_real(a) + to_real(b));
  endfunction

  // ---------------- cycle model: slot, owner, pointer, counters -------------
  logic  m_valid;
  int    m_owner, m_ptr;
  fp32_t m_data;
  int    m_gcnt [N];
  int    m_stall;

  always @(negedge clk) begin
    int          gi;
    logic [N-1:0] er, ev;
    logic        free;
    if (!rst_n) begin
      m_valid = 1'b0; m_owner = 0; m_ptr = 0; m_data = '0; m_stall = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
      chk("reset_resp_valid", 64'(resp_valid), 64'd0);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_resp_data", 64'(resp_data), 64'd0);
    end else begin
      free = !m_valid || resp_ready[m_owner];
      gi = -1;
      for (int k = 0; k < N; k++) begin
        if (gi < 0 && req_valid[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
      end
      er = '0;
      if (free && gi >= 0) er[gi] = 1'b1;
      ev = '0;
      if (m_valid) ev[m_owner] = 1'b1;
      chk("model_req_ready", 64'(req_ready), 64'(er));
      chk("model_resp_valid", 64'(resp_valid), 64'(ev));
      chk("model_resp_data", 64'(resp_data), 64'(m_data));
      if ((|req_valid) && er == '0) m_stall++;
      if (er != '0) begin
        m_data  = ref_add(req_a[32*gi +: 32], req_b[32*gi +: 32]);
        m_owner = gi;
        m_valid = 1'b1;
        m_ptr   = (gi + 1) % N;
        m_gcnt[gi]++;
      end else if (m_valid && resp_ready[m_owner]) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  fp32_t specials [6] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                          32'hFF80_0000, 32'h7FC0_0000, 32'h3F80_0000};

  function automatic fp32_t rnd_op();
    if ($urandom_range(0, 15) == 0) return specials[$urandom_range(0, 5)];
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  task automatic load(input int i);
    fp32_t a;
    a = rnd_op();
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = ($urandom_range(0, 7) == 0) ? (a ^ 32'h8000_0000) : rnd_op();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    gi;
    fp32_t held;
    logic [N-1:0] hs;
    fp32_t ca [3] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000};
    fp32_t cb [3] = '{32'hFF80_0000, 32'h3F80_0000, 32'hC000_0000};
    fp32_t cy [3] = '{32'h7FFF_FFFF, 32'h7FC0_0000, 32'hC000_0000};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // hand-computed values pinning the reference model
    chk("pin_1p2", 64'(ref_add(32'h3F80_0000, 32'h4000_0000)), 64'h4040_0000);
    chk("pin_3m1", 64'(ref_add(32'h4040_0000, 32'hBF80_0000)), 64'h4000_0000);
    chk("pin_tie_even", 64'(ref_add(32'h3F80_0000, 32'h3380_0000)), 64'h3F80_0000);
    chk("pin_round_up", 64'(ref_add(32'h3F80_0000, 32'h33C0_0000)), 64'h3F80_0001);
    chk("pin_cancel", 64'(ref_add(32'h4120_0000, 32'hC120_0000)), 64'h0);
    chk("pin_inf_minf", 64'(ref_add(32'h7F80_0000, 32'hFF80_0000)), 64'h7FFF_FFFF);

    // single request
    req_valid = 4'b0001; req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h4000_0000;
    resp_ready = 4'b1111;
    @(negedge clk); chk("single_ready", 64'(req_ready), 64'b0001);
    step(); req_valid = '0;
    @(negedge clk);
    chk("single_resp_valid", 64'(resp_valid), 64'b0001);
    chk("single_resp_data", 64'(resp_data), 64'h4040_0000);

    // all four requesting, full throughput; pointer is now 1
    step(); req_valid = 4'b1111;
    for (int i = 0; i < N; i++) load(i);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      gi = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
      chk("rr_order", 64'(gi), 64'((1 + k) % 4));
      step();
      if (gi >= 0) load(gi);
    end

    // backpressure with the slot owned by requester 1
    req_valid = 4'b0010; resp_ready = 4'b1101;
    @(negedge clk); chk("bp_grant1", 64'(req_ready), 64'b0010);
    step(); req_valid = 4'b1111; load(1);
    @(negedge clk); held = resp_data;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_no_ready", 64'(req_ready), 64'b0000);
      chk("bp_resp_valid", 64'(resp_valid), 64'b0010);
      chk("bp_data_stable", 64'(resp_data), 64'(held));
    end
    step(); resp_ready = 4'b1111;
    @(negedge clk); chk("bp_release_ready", 64'(req_ready), 64'b0100);
    step(); req_valid = '0;

    // special-value pass-through
    for (int k = 0; k < 3; k++) begin
      step(); req_valid = 4'b0001; req_a[31:0] = ca[k]; req_b[31:0] = cb[k];
      @(negedge clk);
      step(); req_valid = '0;
      @(negedge clk); chk("corner_data", 64'(resp_data), 64'(cy[k]));
    end

    // asynchronous reset with a held result
    step(); req_valid = 4'b0001; req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h3F80_0000;
    @(negedge clk);
    step(); req_valid = '0; resp_ready = '0;
    #1 rst_n = 1'b0;
    #1 chk("async_reset_resp", 64'(resp_valid), 64'd0);
    step(); req_valid = 4'b0110; rst_n = 1'b1; resp_ready = 4'b1111;
    @(negedge clk); chk("post_reset_grant", 64'(req_ready), 64'b0010);
    step(); req_valid = '0;

    // randomized traffic with backpressure
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); hs = req_valid & req_ready;
      step();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || hs[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          if (req_valid[i]) load(i);
        end
        resp_ready[i] = ($urandom_range(0, 3) != 0);
      end
    end

`ifdef FP32_ADDER_ARB_PERF_EN
    @(posedge clk); #2;
    for (int i = 0; i < N; i++)
      chk("perf_grant_cnt", 64'(perf_grant_cnt[32*i +: 32]), 64'(m_gcnt[i]));
    chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
